// File: rtl/slide_x_slave_pkg.sv
// Shared types and constants for the slave-port loader and its request holder.
package slide_x_slave_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 64;
  localparam int SIZE_W_DEF = 7;
  localparam int WORD_W     = 32;

  // Access size (in bits) presented on every request; the loader only moves 32-bit words.
  localparam logic [6:0] SIZE_WORD32 = 7'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_DONE,
    ST_READ,
    ST_EMIT,
    ST_FINISH
  } loader_state_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_t;

  // Byte offset of a 32-bit word index.
  function automatic logic [31:0] word_byte_off(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/main_slave_req.sv
// Single-outstanding request holder for channel 0 of the accelerator slave port.
// Channel-1 fields are tied to zero. A request is held stable until the slave
// reports data-ready, then every field drops for at least one cycle.
module main_slave_req
  import slide_x_slave_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_issue,
  input  req_kind_t             i_kind,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic                  o_pending,
  output logic                  o_req_done,
  output logic [DATA_W-1:0]     o_rdata,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy
);

  logic              r_pend;
  logic              r_done;
  logic              r_oe;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [SIZE_W-1:0] r_size;
  logic [DATA_W-1:0] r_rdata;

  // Channel 1 is never used, so its read data and ready strobe are dropped.
  logic w_unused;
  assign w_unused = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

  // Hold one request until data-ready, then release it and pulse completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_rdata <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_pend) begin
        // Ready with nothing outstanding falls through and is ignored.
        if (Sout_DataRdy[0]) begin
          r_pend  <= 1'b0;
          r_done  <= 1'b1;
          r_oe    <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
          r_wdata <= '0;
          r_size  <= '0;
          r_rdata <= Sout_Rdata_ram[DATA_W-1:0];
        end
      end else if (i_issue) begin
        r_pend  <= 1'b1;
        r_oe    <= (i_kind == REQ_READ);
        r_we    <= (i_kind == REQ_WRITE);
        r_addr  <= i_addr;
        r_wdata <= (i_kind == REQ_WRITE) ? i_wdata : '0;
        r_size  <= SIZE_W'(SIZE_WORD32);
      end
    end
  end

  assign o_pending       = r_pend;
  assign o_req_done      = r_done;
  assign o_rdata         = r_rdata;
  assign S_oe_ram        = {1'b0, r_oe};
  assign S_we_ram        = {1'b0, r_we};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, r_addr};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, r_wdata};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, r_size};

endmodule

// File: rtl/main_slave_loader.sv
// Loader for the accelerator slave memory port: preloads words from a stream,
// kicks the core, times it until done, then streams the words back out.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for run_start
// ST_LOAD      | writing input-stream words to base+4*idx
// ST_KICK      | start_port high for this single cycle, count starts at 1
// ST_WAIT_DONE | counting cycles until done_port or TIMEOUT
// ST_READ      | one read request outstanding at base+4*idx
// ST_EMIT      | presenting the read word on the output stream
// ST_FINISH    | run_done pulse, busy already low
module main_slave_loader
  import slide_x_slave_pkg::*;
#(
  parameter int          ADDR_W  = ADDR_W_DEF,
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int          SIZE_W  = SIZE_W_DEF,
  parameter int          NUM_W   = 16,
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run_start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [NUM_W-1:0]      num_words,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  busy,
  output logic                  run_done,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count
);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_base;
  logic [NUM_W-1:0]  r_num;
  logic [NUM_W-1:0]  r_idx;
  logic              r_busy;
  logic              r_run_done;
  logic              r_timeout;
  logic              r_start_port;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_data;
  logic              r_rd_sent;

  logic              w_pending;
  logic              w_req_done;
  logic [DATA_W-1:0] w_rdata;
  logic              w_issue_wr;
  logic              w_issue_rd;
  logic              w_issue;
  req_kind_t         w_kind;
  logic [31:0]       w_off;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [NUM_W-1:0]  w_idx_inc;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_unused;

  // Only the low word of the read data is meaningful.
  assign w_unused = ^w_rdata[DATA_W-1:WORD_W];

  // During LOAD the idx counter advances on issue, so it already equals num
  // when the final write completes; it is cleared again before readback.
  assign w_issue_wr  = (r_state == ST_LOAD) && !w_pending && in_valid && (r_idx != r_num);
  assign w_issue_rd  = (r_state == ST_READ) && !w_pending && !r_rd_sent;
  assign w_issue     = w_issue_wr || w_issue_rd;
  assign w_kind      = w_issue_wr ? REQ_WRITE : REQ_READ;
  assign w_off       = word_byte_off(32'(r_idx));
  assign w_addr      = r_base + w_off[ADDR_W-1:0];
  assign w_wdata     = {{(DATA_W-WORD_W){1'b0}}, in_data};
  assign w_idx_inc   = r_idx + NUM_W'(1);
  assign w_count_nxt = r_count + CNT_W'(1);

  main_slave_req #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W)
  ) u_req (
    .clock           (clock),
    .reset           (reset),
    .i_issue         (w_issue),
    .i_kind          (w_kind),
    .i_addr          (w_addr),
    .i_wdata         (w_wdata),
    .o_pending       (w_pending),
    .o_req_done      (w_req_done),
    .o_rdata         (w_rdata),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  // Run sequencer: state, word index, cycle counter and stream/status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_num        <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
      r_timeout    <= 1'b0;
      r_start_port <= 1'b0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_rd_sent    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run_start) begin
            r_base    <= base_addr;
            r_num     <= num_words;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_timeout <= 1'b0;
            if (num_words == '0) begin
              r_state      <= ST_KICK;
              r_start_port <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (w_issue_wr) r_idx <= w_idx_inc;
          if (w_req_done && (r_idx == r_num)) begin
            r_state      <= ST_KICK;
            r_start_port <= 1'b1;
          end
        end

        ST_KICK: begin
          r_start_port <= 1'b0;
          r_count      <= CNT_W'(1);
          r_idx        <= '0;
          if (done_port) begin
            if (r_num == '0) begin
              r_state    <= ST_FINISH;
              r_run_done <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= ST_READ;
            end
          end else begin
            r_state <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          r_count <= w_count_nxt;
          if (done_port) begin
            if (r_num == '0) begin
              r_state    <= ST_FINISH;
              r_run_done <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= ST_READ;
            end
          end else if (w_count_nxt == CNT_W'(TIMEOUT)) begin
            r_timeout  <= 1'b1;
            r_state    <= ST_FINISH;
            r_run_done <= 1'b1;
            r_busy     <= 1'b0;
          end
        end

        ST_READ: begin
          if (w_issue_rd) r_rd_sent <= 1'b1;
          if (w_req_done) begin
            r_rd_sent   <= 1'b0;
            r_out_data  <= w_rdata[WORD_W-1:0];
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_idx_inc == r_num) begin
              r_state    <= ST_FINISH;
              r_run_done <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_idx   <= w_idx_inc;
              r_state <= ST_READ;
            end
          end
        end

        ST_FINISH: begin
          r_run_done <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = w_issue_wr;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign start_port  = r_start_port;
  assign busy        = r_busy;
  assign run_done    = r_run_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_count;

endmodule

// File: tb/tb_main_slave_loader.sv
// Scoreboard bench for main_slave_loader: slave-memory and core models drive the
// DUT; expected slave requests, output words and run results are queued by the
// stimulus and popped by monitors as the DUT produces them.
module tb_main_slave_loader;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 64;
  localparam int SIZE_W  = 7;
  localparam int NUM_W   = 16;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 50;

  logic                clock;
  logic                reset;
  logic                run_start;
  logic [ADDR_W-1:0]   base_addr;
  logic [NUM_W-1:0]    num_words;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic                start_port;
  logic                done_port;
  logic [1:0]          S_oe_ram;
  logic [1:0]          S_we_ram;
  logic [2*ADDR_W-1:0] S_addr_ram;
  logic [2*DATA_W-1:0] S_Wdata_ram;
  logic [2*SIZE_W-1:0] S_data_ram_size;
  logic [2*DATA_W-1:0] Sout_Rdata_ram;
  logic [1:0]          Sout_DataRdy;
  logic                busy;
  logic                run_done;
  logic                timeout;
  logic [CNT_W-1:0]    cycle_count;

  typedef struct packed { logic we; logic [9:0] addr; logic [31:0] data; } req_t;
  typedef struct packed { logic [31:0] cnt; logic to; } done_t;

  req_t        exp_req[$];
  logic [31:0] exp_out[$];
  done_t       exp_done[$];
  logic [31:0] in_q[$];
  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_done  = 0;

  logic       core_en = 1'b0;
  int         core_delay = 0;
  int         core_cnt = 0;
  int         sl_cnt = 0;
  logic       sl_rdy = 1'b0;
  logic       sl_rd = 1'b0;
  logic [9:0] sl_addr = '0;
  logic       in_fire = 1'b0;
  int         tick = 0;

  main_slave_loader #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .SIZE_W (SIZE_W),
    .NUM_W (NUM_W), .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .run_start       (run_start),
    .base_addr       (base_addr),
    .num_words       (num_words),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .start_port      (start_port),
    .done_port       (done_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy),
    .busy            (busy),
    .run_done        (run_done),
    .timeout         (timeout),
    .cycle_count     (cycle_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Environment models: input stream, output-ready pattern, core, slave memory.
  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done_port = 1'b0;
    Sout_DataRdy = '0; Sout_Rdata_ram = '0;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        sl_cnt = 0; sl_rdy = 1'b0; core_cnt = 0; in_fire = 1'b0;
        Sout_DataRdy = '0; Sout_Rdata_ram = '0; done_port = 1'b0; in_valid = 1'b0;
      end else begin
        if (in_fire && in_q.size() > 0) void'(in_q.pop_front());
        in_fire  = 1'b0;
        in_valid = (in_q.size() > 0);
        in_data  = in_valid ? in_q[0] : 32'h0;

        tick++;
        out_ready = ((tick % 3) != 0);

        done_port = 1'b0;
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) done_port = 1'b1;
        end
        if (start_port && core_en) begin
          if (core_delay == 0) done_port = 1'b1;
          else core_cnt = core_delay;
        end

        if (sl_rdy) begin
          sl_rdy = 1'b0; Sout_DataRdy = '0; Sout_Rdata_ram = '0;
          check("req_released", {62'h0, S_oe_ram[0], S_we_ram[0]}, 64'h0);
        end else if (sl_cnt > 0) begin
          check("req_held", {S_oe_ram[0] | S_we_ram[0], S_addr_ram[9:0]}, {1'b1, sl_addr});
          sl_cnt--;
          if (sl_cnt == 0) begin
            sl_rdy = 1'b1; Sout_DataRdy = 2'b01;
            if (sl_rd) Sout_Rdata_ram = {64'h0, 32'hA5A5_A5A5, mem[sl_addr[9:2]]};
          end
        end else if (S_oe_ram[0] || S_we_ram[0]) begin
          if (exp_req.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL req_unexpected: got we=%0b oe=%0b addr=%0d, expected no request",
                     S_we_ram[0], S_oe_ram[0], S_addr_ram[9:0]);
          end else begin
            req_t r;
            r = exp_req.pop_front();
            check("req_kind_addr_data", {S_we_ram[0], S_oe_ram[0], S_addr_ram[9:0], S_Wdata_ram[31:0]},
                  {r.we, ~r.we, r.addr, r.data});
          end
          check("req_ch1_idle", {S_oe_ram[1], S_we_ram[1], S_addr_ram[19:10]}, 64'h0);
          check("req_wdata_hi", S_Wdata_ram[127:64] | {32'h0, S_Wdata_ram[63:32]}, 64'h0);
          check("req_size", S_data_ram_size, {7'd0, 7'd32});
          if (S_we_ram[0]) mem[S_addr_ram[9:2]] = S_Wdata_ram[31:0];
          sl_addr = S_addr_ram[9:0];
          sl_rd   = S_oe_ram[0];
          sl_cnt  = S_oe_ram[0] ? 2 : 1;
        end
      end
      @(negedge clock);
      in_fire = reset && in_valid && in_ready;
    end
  end

  // Output-side monitor: readback words, run results, start pulses, oe/we exclusivity.
  initial begin
    logic        prev_start;
    logic        prev_wait;
    logic [31:0] prev_data;
    prev_start = 1'b0; prev_wait = 1'b0; prev_data = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_start = 1'b0; prev_wait = 1'b0;
      end else begin
        if (S_oe_ram != 2'b00 || S_we_ram != 2'b00)
          check("oe_we_excl", {63'h0, S_oe_ram[0] & S_we_ram[0]}, 64'h0);
        if (prev_wait) check("out_held", {out_valid, out_data}, {1'b1, prev_data});
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL out_unexpected: got out_data=0x%0h, expected no output word", out_data);
          end else begin
            check("out_data", out_data, exp_out.pop_front());
          end
        end
        prev_wait = out_valid && !out_ready;
        prev_data = out_data;
        if (run_done) begin
          n_done++;
          if (exp_done.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL run_done_unexpected: got run_done=1, expected none");
          end else begin
            done_t e;
            e = exp_done.pop_front();
            check("cycle_count", cycle_count, e.cnt);
            check("timeout_flag", timeout, e.to);
            check("busy_at_done", busy, 0);
          end
        end
        if (start_port) begin
          n_start++;
          check("start_one_cycle", prev_start, 0);
        end
        prev_start = start_port;
      end
    end
  end

  task automatic pulse_run(input logic [9:0] b, input logic [15:0] n);
    @(posedge clock); #1;
    base_addr = b; num_words = n; run_start = 1'b1;
    @(posedge clock); #1;
    run_start = 1'b0;
  endtask

  task automatic do_run(input string tag, input logic [9:0] b, input int n, input logic [31:0] w [4],
                        input logic en, input int dly, input logic [31:0] ecnt, input logic eto);
    int s0;
    int d0;
    int budget;
    logic [9:0] a;
    s0 = n_start; d0 = n_done;
    for (int i = 0; i < n; i++) begin
      a = b + 10'(4 * i);
      in_q.push_back(w[i]);
      exp_req.push_back('{1'b1, a, w[i]});
    end
    if (!eto) begin
      for (int i = 0; i < n; i++) begin
        a = b + 10'(4 * i);
        exp_req.push_back('{1'b0, a, 32'h0});
        exp_out.push_back(w[i]);
      end
    end
    exp_done.push_back('{ecnt, eto});
    core_en = en; core_delay = dly;
    pulse_run(b, 16'(n));
    budget = 0;
    while (n_done == d0 && budget < 2000) begin
      @(posedge clock);
      budget++;
    end
    if (n_done == d0) begin
      n_tests++; n_fail++;
      $display("FAIL %s run_done_wait: got no run_done, expected one within 2000 cycles", tag);
    end
    repeat (4) @(posedge clock);
    #1;
    check({tag, " start_pulses"}, 64'(n_start - s0), 1);
    check({tag, " done_pulses"}, 64'(n_done - d0), 1);
    check({tag, " reqs_left"}, 64'(exp_req.size()), 0);
    check({tag, " outs_left"}, 64'(exp_out.size()), 0);
    check({tag, " results_left"}, 64'(exp_done.size()), 0);
    check({tag, " busy_after"}, busy, 0);
    exp_req.delete(); exp_out.delete(); exp_done.delete(); in_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    reset = 1'b1; run_start = 1'b0; base_addr = '0; num_words = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_status", {busy, run_done, timeout, start_port, out_valid, in_ready, S_oe_ram, S_we_ram}, 0);
    check("reset_count", cycle_count, 0);
    check("reset_addr_data", {S_addr_ram, out_data}, 0);
    #3 reset = 1'b1;

    do_run("basic4", 10'd0, 4, '{32'd5, 32'd3, 32'd9, 32'd1}, 1'b1, 10, 32'd11, 1'b0);
    do_run("zero_words", 10'd0, 0, '{32'd0, 32'd0, 32'd0, 32'd0}, 1'b1, 10, 32'd11, 1'b0);
    do_run("addr_wrap", 10'd1020, 2, '{32'hDEAD_0001, 32'h0000_BEEF, 32'd0, 32'd0}, 1'b1, 10, 32'd11, 1'b0);
    do_run("done_in_kick", 10'd8, 1, '{32'd42, 32'd0, 32'd0, 32'd0}, 1'b1, 0, 32'd1, 1'b0);
    do_run("timeout", 10'd40, 1, '{32'd7, 32'd0, 32'd0, 32'd0}, 1'b0, 0, 32'd50, 1'b1);

    // Abort a run asynchronously while a write request is on the port.
    for (int i = 0; i < 3; i++) begin
      in_q.push_back(32'(10 + i));
      exp_req.push_back('{1'b1, 10'(16 + 4 * i), 32'(10 + i)});
    end
    core_en = 1'b1; core_delay = 10;
    pulse_run(10'd16, 16'd3);
    b = 0;
    while (!S_we_ram[0] && b < 100) begin
      @(posedge clock); #1;
      b++;
    end
    check("midload_we_seen", {63'h0, S_we_ram[0]}, 1);
    #1 reset = 1'b0;
    #1;
    check("midload_reset_status", {busy, run_done, timeout, start_port, out_valid, in_ready, S_oe_ram, S_we_ram}, 0);
    check("midload_reset_port", {S_addr_ram, S_data_ram_size}, 0);
    check("midload_reset_wdata", S_Wdata_ram[63:0], 0);
    exp_req.delete(); exp_out.delete(); exp_done.delete(); in_q.delete();
    repeat (3) @(posedge clock);
    #4 reset = 1'b1;

    do_run("after_reset", 10'd16, 2, '{32'd100, 32'd200, 32'd0, 32'd0}, 1'b1, 10, 32'd11, 1'b0);

    repeat (5) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
